// File: rtl/calc_core_param.sv
// Decimal keypad-command calculator core with NDIG display digits.
// Binary signed operands, shift-add multiply and a double-dabble BCD display path.
module calc_core_param #(
   parameter int unsigned NDIG = 8,
   parameter int unsigned DW   = 27
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [3:0]        cmd,
   input  logic              cmd_valid,
   output logic              busy,
   output logic [4*NDIG-1:0] digits,
   output logic [NDIG-1:0]   blank,
   output logic              neg,
   output logic              err
);

   localparam int unsigned PW = 2 * DW;
   localparam int unsigned BW = 4 * NDIG;
   localparam int unsigned CW = $clog2(NDIG + 1);
   localparam int unsigned IW = $clog2(DW + 1);

   function automatic logic [PW-1:0] pow10(input int unsigned n);
      logic [PW-1:0] r;
      r = PW'(1);
      for (int unsigned i = 0; i < n; i++) r = r * PW'(10);
      return r;
   endfunction

   localparam logic [PW-1:0]   LIMIT     = pow10(NDIG);
   localparam logic [NDIG-1:0] BLANK_RST = ~NDIG'(1);
   localparam logic [3:0]      CMD_CE    = 4'hD;
   localparam logic [3:0]      CMD_EQ    = 4'hE;
   localparam logic [3:0]      CMD_CA    = 4'hF;

   if ((PW'(1) << DW) < LIMIT) begin : g_dw_check
      $error("calc_core_param: DW is too narrow to hold NDIG decimal digits");
   end

   typedef enum logic [2:0] {
      S_IDLE_A, S_OP_WAIT, S_ENTER_B, S_MUL, S_FIN, S_CONV, S_RESULT, S_ERR
   } state_e;
   typedef enum logic [1:0] {OP_NONE, OP_ADD, OP_SUB, OP_MUL} op_e;

   state_e            state_q, tgt_q;
   op_e               op_q;
   logic signed [DW:0] a_q, b_q;
   logic [CW-1:0]     cnt_q;
   logic              dst_b_q;
   logic [PW-1:0]     vmag_q;
   logic              vneg_q;
   logic [PW-1:0]     prod_q, mcand_q;
   logic [DW-1:0]     mplier_q;
   logic [IW-1:0]     iter_q;
   logic [BW-1:0]     bcd_q;
   logic [DW-1:0]     bin_q;
   logic              busy_q, neg_q, err_q;
   logic [BW-1:0]     digits_q;
   logic [NDIG-1:0]   blank_q;

   logic              accept_c, clear_c, digit_ok_c;
   logic [DW-1:0]     ent_mag_c, ent_next_c, a_mag_c, b_mag_c;
   logic [DW+1:0]     a_ext_c, b_ext_c, sum_c, sum_mag_c;
   logic [PW-1:0]     prod_nxt_c;
   logic              ovf_c, fin_neg_c;
   logic [DW:0]       fin_mag_c;
   logic signed [DW:0] fin_val_c;

   assign accept_c   = cmd_valid && !busy_q;
   assign clear_c    = !reset || (accept_c && cmd == CMD_CA);
   assign ent_mag_c  = (state_q == S_ENTER_B) ? b_q[DW-1:0] : a_q[DW-1:0];
   assign ent_next_c = ent_mag_c * DW'(10) + DW'(cmd);
   assign digit_ok_c = (cnt_q != CW'(NDIG)) && !(ent_mag_c == '0 && cmd == 4'd0);
   assign a_mag_c    = a_q[DW] ? DW'(-a_q) : a_q[DW-1:0];
   assign b_mag_c    = b_q[DW] ? DW'(-b_q) : b_q[DW-1:0];
   assign a_ext_c    = {a_q[DW], a_q};
   assign b_ext_c    = {b_q[DW], b_q};
   assign sum_c      = (op_q == OP_SUB) ? a_ext_c - b_ext_c : a_ext_c + b_ext_c;
   assign sum_mag_c  = sum_c[DW+1] ? -sum_c : sum_c;
   assign prod_nxt_c = mplier_q[0] ? prod_q + mcand_q : prod_q;
   assign ovf_c      = vmag_q >= LIMIT;
   assign fin_neg_c  = vneg_q && (vmag_q != '0);
   assign fin_mag_c  = vmag_q[DW:0];
   assign fin_val_c  = fin_neg_c ? -fin_mag_c : fin_mag_c;

   // One double-dabble step plus the blank mask of its result.
   logic [BW-1:0]    bcd_adj_c, dd_bcd_c;
   logic [DW-1:0]    dd_bin_c;
   logic [BW+DW-1:0] dd_shift_c;
   logic [NDIG-1:0]  dd_blank_c;
   logic             zero_run_c;
   always_comb begin
      bcd_adj_c = bcd_q;
      for (int unsigned i = 0; i < NDIG; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj_c[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
      dd_shift_c = {bcd_adj_c, bin_q} << 1;
      dd_bcd_c   = dd_shift_c[BW+DW-1:DW];
      dd_bin_c   = dd_shift_c[DW-1:0];
      dd_blank_c = '0;
      zero_run_c = 1'b1;
      for (int unsigned i = NDIG - 1; i >= 1; i--) begin
         zero_run_c    = zero_run_c && (dd_bcd_c[4*i +: 4] == 4'd0);
         dd_blank_c[i] = zero_run_c;
      end
   end

   // Command decode for the settled states.
   logic          go_op_c, go_fin_c, go_mul_c, ld_neg_c, ld_dst_b_c;
   logic [PW-1:0] ld_mag_c;
   state_e        ld_tgt_c;
   logic [CW-1:0] new_cnt_c;
   op_e           new_op_c, cmd_op_c;
   always_comb begin
      go_op_c    = 1'b0;
      go_fin_c   = 1'b0;
      go_mul_c   = 1'b0;
      ld_neg_c   = 1'b0;
      ld_dst_b_c = 1'b0;
      ld_mag_c   = '0;
      ld_tgt_c   = state_q;
      new_cnt_c  = cnt_q;
      new_op_c   = op_q;
      cmd_op_c   = op_e'(2'(cmd - 4'd9));
      if (accept_c) begin
         if (cmd <= 4'd9) begin
            case (state_q)
               S_IDLE_A, S_ENTER_B: if (digit_ok_c) begin
                  go_fin_c   = 1'b1;
                  ld_mag_c   = PW'(ent_next_c);
                  ld_dst_b_c = (state_q == S_ENTER_B);
                  new_cnt_c  = cnt_q + CW'(1);
               end
               S_OP_WAIT, S_RESULT: begin
                  go_fin_c   = 1'b1;
                  ld_mag_c   = PW'(cmd);
                  ld_dst_b_c = (state_q == S_OP_WAIT);
                  ld_tgt_c   = (state_q == S_OP_WAIT) ? S_ENTER_B : S_IDLE_A;
                  new_cnt_c  = CW'(cmd != 4'd0);
                  if (state_q == S_RESULT) new_op_c = OP_NONE;
               end
               default: ;
            endcase
         end else if (cmd == CMD_CE) begin
            if (state_q == S_IDLE_A || state_q == S_ENTER_B) begin
               go_fin_c   = 1'b1;
               ld_dst_b_c = (state_q == S_ENTER_B);
               new_cnt_c  = '0;
            end
         end else if (cmd != CMD_CA) begin
            if (state_q == S_ENTER_B) begin
               // Evaluate A op B; an op command chains, = parks in RESULT.
               ld_tgt_c = (cmd == CMD_EQ) ? S_RESULT : S_OP_WAIT;
               if (cmd != CMD_EQ) new_op_c = cmd_op_c;
               if (op_q == OP_MUL) begin
                  go_mul_c = 1'b1;
                  ld_neg_c = a_q[DW] ^ b_q[DW];
               end else begin
                  go_fin_c = 1'b1;
                  ld_mag_c = PW'(sum_mag_c);
                  ld_neg_c = sum_c[DW+1];
               end
            end else if (cmd != CMD_EQ && state_q != S_MUL && state_q != S_FIN &&
                         state_q != S_CONV && state_q != S_ERR) begin
               go_op_c  = 1'b1;
               new_op_c = cmd_op_c;
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (clear_c) begin
         state_q  <= S_IDLE_A;
         tgt_q    <= S_IDLE_A;
         op_q     <= OP_NONE;
         a_q      <= '0;
         b_q      <= '0;
         cnt_q    <= '0;
         dst_b_q  <= 1'b0;
         vmag_q   <= '0;
         vneg_q   <= 1'b0;
         prod_q   <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         iter_q   <= '0;
         bcd_q    <= '0;
         bin_q    <= '0;
         busy_q   <= 1'b0;
         digits_q <= '0;
         blank_q  <= BLANK_RST;
         neg_q    <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE_A, S_OP_WAIT, S_ENTER_B, S_RESULT: begin
               op_q  <= new_op_c;
               cnt_q <= new_cnt_c;
               if (go_op_c) state_q <= S_OP_WAIT;
               if (go_fin_c || go_mul_c) begin
                  busy_q   <= 1'b1;
                  tgt_q    <= ld_tgt_c;
                  dst_b_q  <= ld_dst_b_c;
                  vmag_q   <= ld_mag_c;
                  vneg_q   <= ld_neg_c;
                  prod_q   <= '0;
                  mcand_q  <= PW'(a_mag_c);
                  mplier_q <= b_mag_c;
                  iter_q   <= '0;
                  state_q  <= go_mul_c ? S_MUL : S_FIN;
               end
            end
            S_MUL: begin
               prod_q   <= prod_nxt_c;
               mcand_q  <= mcand_q << 1;
               mplier_q <= mplier_q >> 1;
               iter_q   <= iter_q + IW'(1);
               if (iter_q == IW'(DW - 1)) begin
                  vmag_q  <= prod_nxt_c;
                  state_q <= S_FIN;
               end
            end
            S_FIN: begin
               if (ovf_c) begin
                  state_q  <= S_ERR;
                  busy_q   <= 1'b0;
                  err_q    <= 1'b1;
                  digits_q <= '0;
                  blank_q  <= BLANK_RST;
                  neg_q    <= 1'b0;
               end else begin
                  if (dst_b_q) b_q <= fin_val_c;
                  else         a_q <= fin_val_c;
                  vneg_q  <= fin_neg_c;
                  bcd_q   <= '0;
                  bin_q   <= vmag_q[DW-1:0];
                  iter_q  <= '0;
                  state_q <= S_CONV;
               end
            end
            S_CONV: begin
               bcd_q  <= dd_bcd_c;
               bin_q  <= dd_bin_c;
               iter_q <= iter_q + IW'(1);
               if (iter_q == IW'(DW - 1)) begin
                  digits_q <= dd_bcd_c;
                  blank_q  <= dd_blank_c;
                  neg_q    <= vneg_q;
                  busy_q   <= 1'b0;
                  state_q  <= tgt_q;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy   = busy_q;
   assign digits = digits_q;
   assign blank  = blank_q;
   assign neg    = neg_q;
   assign err    = err_q;

endmodule

// File: tb/tb_calc_core_param.sv
// Bench for calc_core_param: directed sequences plus random commands,
// checked against an integer-arithmetic calculator model.
module tb_calc_core_param;

   localparam int NDIG = 8;
   localparam int DW   = 27;
   localparam int MA = 0, MOPW = 1, MB = 2, MRES = 3, MERR = 4;

   logic                clock = 1'b0;
   logic                reset = 1'b0;
   logic [3:0]          cmd = 4'd0;
   logic                cmd_valid = 1'b0;
   logic                busy;
   logic [4*NDIG-1:0]   digits;
   logic [NDIG-1:0]     blank;
   logic                neg;
   logic                err;

   calc_core_param #(.NDIG(NDIG), .DW(DW)) dut (
      .clock(clock), .reset(reset), .cmd(cmd), .cmd_valid(cmd_valid),
      .busy(busy), .digits(digits), .blank(blank), .neg(neg), .err(err)
   );

   always #5 clock = ~clock;

   int     n_checks = 0;
   int     n_errors = 0;
   longint lim;
   int     m_mode, m_cnt, m_op;
   longint m_a, m_b, m_disp;
   logic   m_err;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      m_mode = MA; m_cnt = 0; m_op = 0;
      m_a = 0; m_b = 0; m_disp = 0; m_err = 1'b0;
   endtask

   task automatic model_eval(input int tgt, output int lat);
      longint r, mag;
      if (m_op == 1)      r = m_a + m_b;
      else if (m_op == 2) r = m_a - m_b;
      else                r = m_a * m_b;
      mag = (r < 0) ? -r : r;
      if (mag >= lim) begin
         m_mode = MERR; m_err = 1'b1; m_disp = 0;
         lat = (m_op == 3) ? DW + 1 : 1;
      end else begin
         m_a = r; m_disp = r; m_mode = tgt;
         lat = (m_op == 3) ? 2*DW + 1 : DW + 1;
      end
   endtask

   // Expected busy length and new calculator state for one accepted command.
   task automatic model_step(input logic [3:0] c, output int lat);
      longint cur;
      int d;
      lat = 0;
      d = int'(c);
      if (c == 4'hF) model_clear();
      else if (m_mode == MERR) lat = 0;
      else if (d <= 9) begin
         if (m_mode == MA || m_mode == MB) begin
            cur = (m_mode == MA) ? m_a : m_b;
            if (!(m_cnt == NDIG || (cur == 0 && d == 0))) begin
               cur = cur * 10 + d;
               m_cnt++;
               if (m_mode == MA) m_a = cur; else m_b = cur;
               m_disp = cur; lat = DW + 1;
            end
         end else if (m_mode == MOPW) begin
            m_b = d; m_cnt = int'(d != 0); m_mode = MB; m_disp = d; lat = DW + 1;
         end else begin
            m_a = d; m_op = 0; m_cnt = int'(d != 0); m_mode = MA; m_disp = d; lat = DW + 1;
         end
      end else if (c == 4'hD) begin
         if (m_mode == MA) begin m_a = 0; m_cnt = 0; m_disp = 0; lat = DW + 1; end
         if (m_mode == MB) begin m_b = 0; m_cnt = 0; m_disp = 0; lat = DW + 1; end
      end else if (c == 4'hE) begin
         if (m_mode == MB) model_eval(MRES, lat);
      end else begin
         if (m_mode == MB) model_eval(MOPW, lat);
         else m_mode = MOPW;
         m_op = d - 9;
      end
   endtask

   task automatic expect_disp(output logic [4*NDIG-1:0] ed, output logic [NDIG-1:0] eb,
                              output logic en);
      longint mag;
      int hi;
      en  = (m_disp < 0);
      mag = en ? -m_disp : m_disp;
      hi  = 0;
      ed  = '0;
      for (int i = 0; i < NDIG; i++) begin
         ed[4*i +: 4] = 4'(mag % 10);
         if (mag % 10 != 0) hi = i;
         mag = mag / 10;
      end
      for (int i = 0; i < NDIG; i++) eb[i] = (i > hi);
   endtask

   task automatic check_outputs(input string name);
      logic [4*NDIG-1:0] ed;
      logic [NDIG-1:0]   eb;
      logic              en;
      expect_disp(ed, eb, en);
      check({name, " digits"}, 64'(digits), 64'(ed));
      check({name, " blank"},  64'(blank),  64'(eb));
      check({name, " neg"},    64'(neg),    64'(en));
      check({name, " err"},    64'(err),    64'(m_err));
   endtask

   // Issue one command while idle, optionally pulsing junk commands while busy.
   task automatic issue(input logic [3:0] c, input bit noisy);
      logic [4*NDIG-1:0] pd;
      logic [NDIG-1:0]   pb;
      logic              pn, pe;
      int                lat, n;
      bit                stable;
      string             name;
      name = $sformatf("cmd%0h", c);
      expect_disp(pd, pb, pn);
      pe = m_err;
      model_step(c, lat);
      @(negedge clock);
      cmd = c; cmd_valid = 1'b1;
      @(posedge clock); #1;
      cmd_valid = 1'b0;
      n = 0; stable = 1'b1;
      while (busy === 1'b1 && n < 600) begin
         n++;
         if (digits !== pd || blank !== pb || neg !== pn || err !== pe) stable = 1'b0;
         if (noisy) begin
            @(negedge clock);
            cmd = 4'($urandom_range(0, 15)); cmd_valid = 1'b1;
         end
         @(posedge clock); #1;
         cmd_valid = 1'b0;
      end
      check({name, " busy cycles"}, 64'(n), 64'(lat));
      check({name, " stable while busy"}, 64'(stable), 64'(1));
      check_outputs(name);
   endtask

   task automatic issue_seq(input logic [3:0] seq [$]);
      foreach (seq[i]) issue(seq[i], 1'b0);
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      lim = 1;
      for (int i = 0; i < NDIG; i++) lim = lim * 10;
      model_clear();

      repeat (2) @(posedge clock);
      #1;
      check("reset busy", 64'(busy), 64'(0));
      check_outputs("reset");
      @(negedge clock);
      reset = 1'b1;

      issue_seq('{4'd1, 4'hA, 4'd1, 4'hE});
      issue_seq('{4'd3, 4'hB, 4'd5, 4'hE});
      issue(4'hF, 1'b0);
      issue_seq('{4'd9, 4'd9, 4'd9, 4'd9, 4'hC, 4'd9, 4'd9, 4'd9, 4'd9, 4'hE});
      issue_seq('{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'hC, 4'd1, 4'd0, 4'hE});
      issue(4'd5, 1'b0);
      issue(4'hF, 1'b0);
      issue_seq('{4'd2, 4'hA, 4'd3, 4'hC, 4'd4, 4'hE, 4'hF});
      issue_seq('{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'hA});
      issue(4'd2, 1'b1);
      issue(4'hE, 1'b1);
      issue(4'hD, 1'b0);

      // Reset in the middle of a multiply.
      issue_seq('{4'hF, 4'd3, 4'hC, 4'd4});
      @(negedge clock);
      cmd = 4'hE; cmd_valid = 1'b1;
      @(posedge clock); #1;
      cmd_valid = 1'b0;
      repeat (10) @(posedge clock);
      #1;
      check("mid-mul busy", 64'(busy), 64'(1));
      @(negedge clock);
      reset = 1'b0;
      @(posedge clock); #1;
      model_clear();
      check("mid-mul reset busy", 64'(busy), 64'(0));
      check_outputs("mid-mul reset");
      @(negedge clock);
      reset = 1'b1;
      repeat (20) @(posedge clock);
      #1;
      check("idle busy", 64'(busy), 64'(0));
      check_outputs("idle");
      issue(4'd5, 1'b0);

      for (int k = 0; k < 300; k++) begin
         int unsigned r;
         logic [3:0]  c;
         r = $urandom_range(0, 99);
         if (m_mode == MERR && r < 50) c = 4'hF;
         else if (r < 55) c = 4'($urandom_range(0, 9));
         else if (r < 75) c = 4'($urandom_range(10, 12));
         else if (r < 88) c = 4'hE;
         else if (r < 95) c = 4'hD;
         else c = 4'hF;
         issue(c, $urandom_range(0, 3) == 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
